// File: rtl/combo_checker_pkg.sv
// Shared state encoding and the digit-slice helper for the combination lock checker.
package combo_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_ERROR   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam int unsigned MAX_CODE_W  = 256;
  localparam int unsigned MAX_DIGIT_W = 32;

  // Extracts digit idx (w bits wide) from a packed code; callers zero-extend into the fixed widths.
  function automatic logic [MAX_DIGIT_W-1:0] digit_slice(input logic [MAX_CODE_W-1:0] code,
                                                         input int unsigned idx,
                                                         input int unsigned w);
    logic [MAX_DIGIT_W-1:0] mask;
    mask = '1;
    mask = mask >> (MAX_DIGIT_W - w);
    return MAX_DIGIT_W'(code >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/combo_checker_if.sv
// Key-pulse, code and status bundle between the pulse circuit and the combination checker.
interface combo_checker_if #(
  parameter int unsigned DIGIT_W  = 4,
  parameter int unsigned CODE_LEN = 4
);
  logic                                Enter_Pulse;
  logic                                Clear_Pulse;
  logic [DIGIT_W-1:0]                  Digit;
  logic [CODE_LEN*DIGIT_W-1:0]         Code;
  logic                                Unlocked;
  logic                                Error;
  logic                                Locked_Out;
  logic [$clog2(CODE_LEN+1)-1:0]       Digit_Count;

  modport master (
    output Enter_Pulse, Clear_Pulse, Digit, Code,
    input  Unlocked, Error, Locked_Out, Digit_Count
  );

  modport slave (
    input  Enter_Pulse, Clear_Pulse, Digit, Code,
    output Unlocked, Error, Locked_Out, Digit_Count
  );
endinterface

// File: rtl/combo_checker_hold_timer.sv
// Loadable down-counter that holds at zero; done flags the zero count.
module hold_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);
endmodule

// File: rtl/combo_checker.sv
// Combination lock sequence checker: collects CODE_LEN digits, then opens, errors or locks out.
module combo_checker
  import combo_lock_pkg::*;
#(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned UNLOCK_CYCLES  = 8,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  combo_checker_if.slave  bus
);
  localparam int unsigned IDX_W  = $clog2(CODE_LEN + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TMR_W  = $clog2(TMR_MAX + 1);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               mismatch, mismatch_n;
  logic [FAIL_W-1:0]  fail_cnt, fail_n;
  logic               hit;
  logic               load;
  logic [TMR_W-1:0]   load_value;
  logic               timer_done;

  logic               unlocked_q;
  logic               error_q;
  logic               locked_q;
  logic [IDX_W-1:0]   count_q;

  hold_timer #(.W(TMR_W)) u_timer (
    .clk        (Clock),
    .rst        (Reset),
    .load       (load),
    .load_value (load_value),
    .done       (timer_done)
  );

  assign hit = (digit_slice(MAX_CODE_W'(bus.Code), 32'(idx), DIGIT_W) == MAX_DIGIT_W'(bus.Digit));

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    mismatch_n = mismatch;
    fail_n     = fail_cnt;
    load       = 1'b0;
    load_value = '0;
    unique case (state)
      ST_ENTRY: begin
        if (bus.Clear_Pulse) begin
          idx_n      = '0;
          mismatch_n = 1'b0;
        end else if (bus.Enter_Pulse) begin
          if (idx == IDX_W'(CODE_LEN - 1)) begin
            idx_n      = '0;
            mismatch_n = 1'b0;
            if (!mismatch && hit) begin
              state_n    = ST_OPEN;
              load       = 1'b1;
              load_value = TMR_W'(UNLOCK_CYCLES - 1);
              fail_n     = '0;
            end else if (fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
              state_n    = ST_LOCKOUT;
              load       = 1'b1;
              load_value = TMR_W'(LOCKOUT_CYCLES - 1);
              fail_n     = '0;
            end else begin
              state_n = ST_ERROR;
              fail_n  = fail_cnt + 1'b1;
            end
          end else begin
            // Wrong digits are only remembered, so the entry always runs to full length.
            idx_n      = idx + 1'b1;
            mismatch_n = mismatch | ~hit;
          end
        end
      end
      ST_OPEN: begin
        if (bus.Clear_Pulse || timer_done) state_n = ST_ENTRY;
      end
      ST_ERROR: begin
        state_n = ST_ENTRY;
      end
      ST_LOCKOUT: begin
        if (timer_done) state_n = ST_ENTRY;
      end
      default: state_n = ST_ENTRY;
    endcase
  end

  // Outputs are registered from the next-state values, so they line up with the state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_ENTRY;
      idx        <= '0;
      mismatch   <= 1'b0;
      fail_cnt   <= '0;
      unlocked_q <= 1'b0;
      error_q    <= 1'b0;
      locked_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      mismatch   <= mismatch_n;
      fail_cnt   <= fail_n;
      unlocked_q <= (state_n == ST_OPEN);
      error_q    <= (state_n == ST_ERROR);
      locked_q   <= (state_n == ST_LOCKOUT);
      count_q    <= (state_n == ST_ENTRY) ? idx_n : '0;
    end
  end

  assign bus.Unlocked    = unlocked_q;
  assign bus.Error       = error_q;
  assign bus.Locked_Out  = locked_q;
  assign bus.Digit_Count = count_q;
endmodule
